// File: rtl/inv_out_buffer.sv
// Show-ahead output buffer behind the inverter stage: small register FIFO with
// drop accounting (sticky overflow, saturating drop count) and an XOR checksum of accepted words.
module inv_out_buffer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         di,
   input  logic                     di_valid,
   output logic                     di_ready,
   output logic [WIDTH-1:0]         dout,
   output logic                     do_valid,
   input  logic                     do_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic [7:0]               drop_cnt,
   output logic [WIDTH-1:0]         csum,
   input  logic                     clr_stat
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             ovf_reg, ovf_next;
   logic [7:0]       drop_reg, drop_next;
   logic [WIDTH-1:0] csum_reg, csum_next;

   logic             accept, pop, drop;
   logic [7:0]       drop_base;
   logic [WIDTH-1:0] csum_base;

   // Handshake flags depend only on registered occupancy, so do_ready never
   // reaches di_ready and a full buffer cannot be refilled in the cycle it pops.
   always_comb begin
      di_ready = (count_reg != FULL_COUNT);
      do_valid = (count_reg != '0);
      accept   = di_valid && di_ready;
      drop     = di_valid && !di_ready;
      pop      = do_valid && do_ready;
   end

   always_comb begin
      wr_ptr_next = accept ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
      rd_ptr_next = pop    ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
      count_next  = count_reg + CW'(accept) - CW'(pop);
   end

   // A clear and a same-cycle event combine: the event lands on the cleared value.
   always_comb begin
      drop_base = clr_stat ? 8'd0 : drop_reg;
      csum_base = clr_stat ? '0 : csum_reg;
      ovf_next  = clr_stat ? drop : (ovf_reg | drop);
      drop_next = (drop && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
      csum_next = accept ? (csum_base ^ di) : csum_base;
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (rst) begin
               mem_reg[gi] <= '0;
            end else if (accept && wr_ptr_reg == PW'(gi)) begin
               mem_reg[gi] <= di;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
         drop_reg   <= 8'd0;
         csum_reg   <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         ovf_reg    <= ovf_next;
         drop_reg   <= drop_next;
         csum_reg   <= csum_next;
      end
   end

   assign dout     = mem_reg[rd_ptr_reg];
   assign count    = count_reg;
   assign ovf      = ovf_reg;
   assign drop_cnt = drop_reg;
   assign csum     = csum_reg;

endmodule

// File: tb/tb_inv_out_buffer.sv
// Self-checking bench for inv_out_buffer: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_inv_out_buffer;

   localparam int W = 16;
   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst, di_valid, do_ready, clr_stat;
   logic [W-1:0]   di;
   logic           di_ready, do_valid, ovf;
   logic [W-1:0]   dout, csum;
   logic [2:0]     count;
   logic [7:0]     drop_cnt;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [W-1:0] q[$];
   bit           m_ovf;
   int           m_drop;
   logic [W-1:0] m_csum;

   inv_out_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .di(di), .di_valid(di_valid), .di_ready(di_ready),
      .dout(dout), .do_valid(do_valid), .do_ready(do_ready), .count(count),
      .ovf(ovf), .drop_cnt(drop_cnt), .csum(csum), .clr_stat(clr_stat)
   );

   always #5 clk = ~clk;

   // One clock cycle: drive inputs, advance the model at the edge, settle.
   task automatic cyc(input logic r, input logic dv, input logic [W-1:0] d,
                      input logic dr, input logic cs);
      bit full, acc, pp, dropped;
      logic [W-1:0] tmp;
      rst = r; di_valid = dv; di = d; do_ready = dr; clr_stat = cs;
      @(posedge clk);
      if (r) begin
         q.delete(); m_ovf = 0; m_drop = 0; m_csum = '0;
      end else begin
         full    = (q.size() == D);
         acc     = dv && !full;
         dropped = dv && full;
         pp      = dr && (q.size() != 0);
         if (cs) begin m_ovf = 0; m_drop = 0; m_csum = '0; end
         if (dropped) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
         if (acc) m_csum ^= d;
         if (pp) tmp = q.pop_front();
         if (acc) q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset;
      cyc(1, 1, 16'h1234, 1, 0);
      cyc(1, 0, 0, 0, 0);
      checks++; if (do_valid !== 1'b0) begin errors++; $display("FAIL reset_do_valid got %b want 0", do_valid); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (di_ready !== 1'b1) begin errors++; $display("FAIL reset_di_ready got %b want 1", di_ready); end
      checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_do got %h want 0000", dout); end
      checks++; if ({ovf, drop_cnt, csum} !== 25'd0) begin errors++; $display("FAIL reset_stats got ovf=%b drop=%0d csum=%h want 0", ovf, drop_cnt, csum); end
      $display("test_reset done");
   endtask

   task automatic test_first_word;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 16'hFFF0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      checks++; if (dout !== 16'hFFF0) begin errors++; $display("FAIL first_do got %h want fff0", dout); end
      checks++; if (do_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", do_valid); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL first_count got %0d want 1", count); end
      checks++; if (csum !== 16'hFFF0) begin errors++; $display("FAIL first_csum got %h want fff0", csum); end
      $display("test_first_word done");
   endtask

   task automatic test_fill_drop;
      cyc(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) cyc(0, 1, W'(i), 0, 0);
      cyc(0, 0, 0, 0, 0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
      checks++; if (di_ready !== 1'b0) begin errors++; $display("FAIL fill_di_ready got %b want 0", di_ready); end
      cyc(0, 1, 16'h0005, 0, 0);
      cyc(0, 0, 0, 0, 0);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b want 1", ovf); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
      checks++; if (csum !== 16'h0004) begin errors++; $display("FAIL drop_csum got %h want 0004", csum); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d want 4", count); end
      $display("test_fill_drop done");
   endtask

   task automatic test_full_pop;
      // continues from the full buffer holding 1..4
      checks++; if (dout !== 16'h0001) begin errors++; $display("FAIL fullpop_head got %h want 0001", dout); end
      cyc(0, 1, 16'h0006, 1, 0);
      cyc(0, 0, 0, 0, 0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d want 3", count); end
      checks++; if (dout !== 16'h0002) begin errors++; $display("FAIL fullpop_head2 got %h want 0002", dout); end
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fullpop_drop got %0d want 2", drop_cnt); end
      checks++; if (csum !== 16'h0004) begin errors++; $display("FAIL fullpop_csum got %h want 0004", csum); end
      $display("test_full_pop done");
   endtask

   task automatic test_clr_stat;
      // count 3, ovf set from earlier drops
      cyc(0, 1, 16'h00AA, 0, 1);
      cyc(0, 0, 0, 0, 0);
      checks++; if (csum !== 16'h00AA) begin errors++; $display("FAIL clr_csum got %h want 00aa", csum); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", ovf); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_drop got %0d want 0", drop_cnt); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL clr_count got %0d want 4", count); end
      // full now: a clear with a same-cycle drop
      cyc(0, 1, 16'h0BAD, 0, 1);
      cyc(0, 0, 0, 0, 0);
      checks++; if ({ovf, drop_cnt, csum} !== {1'b1, 8'd1, 16'h0}) begin errors++; $display("FAIL clr_drop_same got ovf=%b drop=%0d csum=%h want 1 1 0000", ovf, drop_cnt, csum); end
      $display("test_clr_stat done");
   endtask

   task automatic test_saturate;
      for (int i = 0; i < 260; i++) cyc(0, 1, W'($urandom), 0, 0);
      cyc(0, 0, 0, 0, 0);
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d want 255", drop_cnt); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL sat_count got %0d want 4", count); end
      $display("test_saturate done");
   endtask

   task automatic test_stream;
      logic [W-1:0] sent[$];
      logic [W-1:0] exp_w;
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] w;
         w = W'($urandom);
         // the word on dout now is popped at the coming edge
         if (do_valid) begin
            exp_w = sent.pop_front();
            checks++; if (dout !== exp_w) begin errors++; $display("FAIL stream_order[%0d] got %h want %h", i, dout, exp_w); end
         end
         sent.push_back(w);
         cyc(0, 1, w, 1, 0);
         checks++; if (count > 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want <=1", i, count); end
      end
      checks++; if (drop_cnt !== 8'd0 || ovf !== 1'b0) begin errors++; $display("FAIL stream_drops got ovf=%b drop=%0d want 0", ovf, drop_cnt); end
      checks++; if (dout !== sent[0] || do_valid !== 1'b1) begin errors++; $display("FAIL stream_last got %h/%b want %h/1", dout, do_valid, sent[0]); end
      $display("test_stream done");
   endtask

   task automatic test_reset_mid;
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, W'(16'h0100 + i), 0, 0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_precount got %0d want 3", count); end
      cyc(1, 1, 16'h7777, 1, 0);
      rst = 0; di_valid = 0; do_ready = 0;
      checks++; if (do_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_reset got valid=%b count=%0d want 0 0", do_valid, count); end
      checks++; if (di_ready !== 1'b1 || dout !== 16'h0) begin errors++; $display("FAIL mid_reset_out got ready=%b do=%h want 1 0000", di_ready, dout); end
      $display("test_reset_mid done");
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), W'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
         checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", i, count, q.size()); end
         checks++; if (do_valid !== (q.size() != 0) || di_ready !== (q.size() != D)) begin errors++; $display("FAIL rand_flags[%0d] got v=%b r=%b size %0d", i, do_valid, di_ready, q.size()); end
         if (q.size() != 0) begin
            checks++; if (dout !== q[0]) begin errors++; $display("FAIL rand_do[%0d] got %h want %h", i, dout, q[0]); end
         end
         checks++; if (ovf !== m_ovf || drop_cnt !== 8'(m_drop) || csum !== m_csum) begin errors++; $display("FAIL rand_stats[%0d] got %b/%0d/%h want %b/%0d/%h", i, ovf, drop_cnt, csum, m_ovf, m_drop, m_csum); end
      end
      $display("test_random done");
   endtask

   initial begin
      rst = 1; di_valid = 0; do_ready = 0; clr_stat = 0; di = '0;
      test_reset();
      test_first_word();
      test_fill_drop();
      test_full_pop();
      test_clr_stat();
      test_saturate();
      test_stream();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
